// File: rtl/mem_monitor_pkg.sv
// Shared types for the data-memory write monitor: FSM state encoding and trace entry payload.
package mem_monitor_pkg;

  // Widest address/data word the trace storage can hold; the monitor's WIDTH must not exceed it.
  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned COUNT_W   = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] adr;
    logic [MAX_WIDTH-1:0] data;
  } trace_entry_t;

  // Saturating increment for the 16-bit run counters.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (value == '1) ? value : value + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_write_monitor_trace_ring.sv
// Circular trace of the most recent stores with a newest-relative combinational read port.
module trace_ring
  import mem_monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  trace_entry_t             wr_entry,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output trace_entry_t             rd_entry,
  output logic                     rd_valid,
  output logic                     wrapped
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = IDX_W + 1;

  trace_entry_t       mem [DEPTH];
  logic [IDX_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]  fill;
  logic [IDX_W-1:0]   rd_slot;

  // Pointer, fill level and sticky overwrite flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      fill    <= '0;
      wrapped <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      if (fill == FILL_W'(DEPTH)) begin
        wrapped <= 1'b1;
      end else begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Entry storage needs no reset; validity is tracked by fill.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Index 0 is the newest entry, one slot behind the write pointer; wraps mod DEPTH.
  assign rd_slot  = wr_ptr - IDX_W'(1) - rd_idx;
  assign rd_entry = mem[rd_slot];
  assign rd_valid = FILL_W'(rd_idx) < fill;

endmodule

// File: rtl/mem_write_monitor.sv
// Cycle-accurate checker on the data-memory write port: PASS on the signature store,
// FAIL on a disallowed store, TIMEOUT when the cycle budget runs out.
module mem_write_monitor
  import mem_monitor_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TIMEOUT   = 250,
  parameter int unsigned SIG_ADR   = 100,
  parameter int unsigned SIG_DATA  = 25,
  parameter int unsigned ALLOW_ADR = 96,
  parameter bit          STRICT    = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [WIDTH-1:0]         DataAdr,
  input  logic [WIDTH-1:0]         WriteData,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               state,
  output logic [15:0]              write_count,
  output logic [15:0]              cycle_count,
  output logic                     trace_wrapped,
  input  logic [$clog2(DEPTH)-1:0] trace_idx,
  output logic [WIDTH-1:0]         trace_adr,
  output logic [WIDTH-1:0]         trace_data,
  output logic                     trace_valid
);

  state_t       state_q;
  state_t       state_next;
  logic         run;
  logic         store;
  logic         sig_hit;
  logic         sig_data_ok;
  logic         allow_hit;
  logic         budget_end;
  trace_entry_t wr_entry;
  trace_entry_t rd_entry;

  assign run         = (state_q == ST_RUN);
  // A store coinciding with reset is dropped.
  assign store       = run && MemWrite && !reset;
  assign sig_hit     = (DataAdr == WIDTH'(SIG_ADR));
  assign sig_data_ok = (WriteData == WIDTH'(SIG_DATA));
  assign allow_hit   = (DataAdr == WIDTH'(ALLOW_ADR));
  assign budget_end  = (cycle_count == COUNT_W'(TIMEOUT - 1));

  // Store classification takes priority over the budget expiring in the same cycle.
  always_comb begin
    state_next = state_q;
    if (run) begin
      if (store && sig_hit && sig_data_ok) begin
        state_next = ST_PASS;
      end else if (store && (sig_hit || (STRICT && !allow_hit))) begin
        state_next = ST_FAIL;
      end else if (budget_end) begin
        state_next = ST_TIMEOUT;
      end
    end
  end

  // State, status flags and counters; counters freeze once a terminal state is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      write_count <= '0;
      cycle_count <= '0;
    end else begin
      state_q <= state_next;
      done    <= (state_next != ST_RUN);
      pass    <= (state_next == ST_PASS);
      if (store) begin
        write_count <= sat_inc(write_count);
      end
      // The count tops out at TIMEOUT-1: the final budget cycle does not advance it.
      if (run && !budget_end) begin
        cycle_count <= sat_inc(cycle_count);
      end
    end
  end

  assign state    = state_q;
  assign wr_entry = '{adr: MAX_WIDTH'(DataAdr), data: MAX_WIDTH'(WriteData)};

  trace_ring #(
    .DEPTH (DEPTH)
  ) u_trace_ring (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (store),
    .wr_entry (wr_entry),
    .rd_idx   (trace_idx),
    .rd_entry (rd_entry),
    .rd_valid (trace_valid),
    .wrapped  (trace_wrapped)
  );

  assign trace_adr  = rd_entry.adr[WIDTH-1:0];
  assign trace_data = rd_entry.data[WIDTH-1:0];

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Synthesizable, parametrised monitor on the processor's data-memory write port; it generalises the end-of-run RAM dump into a cycle-accurate checker. It observes every store, keeps a circular trace of the last DEPTH writes, and declares PASS on a signature store, FAIL on a disallowed store, or TIMEOUT after a cycle budget. It sits beside `top`/`dmem` in simulation and on FPGA builds, driving status LEDs or a bench `$finish`.

## Interface
- WIDTH, 32: address and data width.
- DEPTH, 8: trace entries; power of two, ≥2.
- TIMEOUT, 250: run cycles allowed before TIMEOUT; ≥1.
- SIG_ADR, 100: signature store address.
- SIG_DATA, 25: signature store data.
- ALLOW_ADR, 96: the one non-signature address legal in strict mode.
- STRICT, 1: 1 = store to any address other than SIG_ADR/ALLOW_ADR is FAIL; 0 = only a SIG_ADR store with wrong data fails.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- MemWrite  in  1  store strobe, one store per high cycle.
- DataAdr  in  WIDTH  store byte address.
- WriteData  in  WIDTH  store data.
- done  out  1  high in PASS/FAIL/TIMEOUT.
- pass  out  1  high only in PASS.
- state  out  2  encoded state (package enum).
- write_count  out  16  stores seen in RUN, saturating at 0xFFFF.
- cycle_count  out  16  RUN cycles elapsed, saturating.
- trace_wrapped  out  1  sticky; set when a store overwrites an old entry.
- trace_idx  in  log2(DEPTH)  read index; 0 = newest, DEPTH-1 = oldest.
- trace_adr  out  WIDTH  address of the selected entry (combinational read).
- trace_data  out  WIDTH  data of the selected entry.
- trace_valid  out  1  selected entry holds a captured store.

## Operation
- States: RUN(0), PASS(1), FAIL(2), TIMEOUT(3). Reset → RUN.
- In RUN, each cycle with MemWrite=1:
  - The store is captured at the write pointer; pointer += 1 mod DEPTH; write_count += 1.
  - Classification is evaluated on the same store:
    - DataAdr==SIG_ADR && WriteData==SIG_DATA → PASS.
    - DataAdr==SIG_ADR && data mismatch → FAIL.
    - STRICT && DataAdr∉{SIG_ADR, ALLOW_ADR} → FAIL.
    - Otherwise stay in RUN.
- cycle_count increments every RUN cycle. When cycle_count reaches TIMEOUT-1 with no terminal store that cycle → TIMEOUT.
- Simultaneous events: a terminal store in the final budget cycle wins over TIMEOUT.
- Terminal states are sticky until reset. In them, stores are ignored: no capture, and counters are frozen.
- trace_valid for index i is high when i < number of stores captured (saturating at DEPTH).
- trace_wrapped is set on the first store captured when DEPTH entries are already valid.
- X on the inputs while MemWrite=1 is treated as a mismatch; the bench flags it.

## Timing
- Reset values: state=RUN, done=0, pass=0, write_count=0, cycle_count=0, trace_wrapped=0, all trace_valid=0, pointer=0.
- Reset asserted mid-run clears everything at the next edge; a store in the same cycle is dropped.
- Latency: a store sampled at edge N shows in state/done/pass, counters and trace after edge N (registered, 1 cycle).
- Trace read is combinational from trace_idx. Newest entry = pointer-1 mod DEPTH.
- Counters saturate; no wrap.

## Structure
- Package `mem_monitor_pkg`: state enum (2-bit), state encodings, and a `trace_entry_t` struct {adr, data}.
- One sub-module, `trace_ring`: DEPTH×(2·WIDTH) circular buffer holding the write pointer, fill count, wrapped flag and newest-relative read mux.
- FSM, classifiers and counters live in the top.

## Test plan
- Harris-style program: store 7 to 96, then 25 to 100 → done=1, pass=1, write_count=2, trace[0]={100,25}, trace[1]={96,7}.
- STRICT=1, store 5 to 0x44 → state=FAIL at the next edge. A later store of 25 to 100 is ignored: write_count stays 1, state stays FAIL.
- Store 26 to 100 → FAIL. Same run with STRICT=0 and store 5 to 0x44 first → 0x44 store stays RUN, then FAIL on 26.
- TIMEOUT=10, no stores → TIMEOUT after exactly 10 RUN cycles with cycle_count=9; signature store on cycle 10 instead → PASS.
- DEPTH=4, STRICT=0, 6 stores to 96 with data 1..6 → trace_wrapped=1, trace[0]=6, trace[3]=3, all four valid.
- Reset pulse after 3 stores → all outputs return to their reset values; the next store lands in trace[0] with write_count=1.
